// File: rtl/apu_pkg.sv
// Shared APU definitions: frame sequencer step positions and sequencer mode type.
package apu_pkg;

  // Cycle-counter values (CPU cycles since sequence start) at which step events fire.
  localparam int unsigned FS_STEP1   = 7456;
  localparam int unsigned FS_STEP2   = 14912;
  localparam int unsigned FS_STEP3   = 22370;
  localparam int unsigned FS_STEP4   = 29829;
  localparam int unsigned FS_STEP5   = 37280;
  localparam int unsigned FS_WRAP5   = 37281;
  localparam int unsigned FS_IRQ_PRE = 29828;

  typedef enum logic {
    FS_MODE4 = 1'b0,
    FS_MODE5 = 1'b1
  } fs_mode_e;

endpackage

// File: rtl/apu_frame_irq.sv
// Frame IRQ flag register with fixed set/clear priority.
// Ports:
//   clk     system clock
//   rst_n   synchronous active-low reset
//   clr_wr  clear from a $4017 write with inhibit=1 (highest priority)
//   set     step-driven set request (already qualified by inhibit)
//   clr_rd  clear from a $4015 status read (lowest priority)
//   irq     registered flag
module apu_frame_irq (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_wr,
  input  logic set,
  input  logic clr_rd,
  output logic irq
);

  logic irq_d, irq_q;

  // A set coincident with a status read wins, so the read cannot lose the event.
  always_comb begin
    irq_d = irq_q;
    if (clr_wr) begin
      irq_d = 1'b0;
    end else if (set) begin
      irq_d = 1'b1;
    end else if (clr_rd) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;

endmodule

// File: rtl/apu_frame_sequencer.sv
// PAPU frame sequencer: counts CPU-cycle strobes and emits one-clock quarter/half
// frame ticks in 4-step or 5-step mode, and owns the frame IRQ flag.
// Optional feature macro: FRAME_IRQ_EN (IRQ flag, inhibit bit, $4015 read clear).
// Without it frame_irq is tied low and wr_data[6]/status_rd are ignored.
// Ports:
//   clk            system clock
//   rst_n          synchronous active-low reset
//   cpu_ce         one-clk strobe per CPU cycle
//   wr_en          $4017 write strobe
//   wr_data        write data; bit7 = 5-step mode, bit6 = IRQ inhibit
//   status_rd      $4015 read strobe (clears the IRQ flag)
//   quarter_frame  one-clk envelope / linear-counter tick
//   half_frame     one-clk length-counter / sweep tick
//   frame_irq      frame IRQ flag level
//   mode           current sequencer mode (1 = 5-step)
module apu_frame_sequencer
  import apu_pkg::*;
#(
  parameter int unsigned RESET_DELAY = 3,
  parameter int unsigned CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_ce,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       status_rd,
  output logic       quarter_frame,
  output logic       half_frame,
  output logic       frame_irq,
  output logic       mode
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  fs_mode_e         mode_q, mode_d;
  logic             pend_q, pend_d;
  logic [2:0]       dly_q, dly_d;
  logic             qf_q, qf_d;
  logic             hf_q, hf_d;
  logic             irq_step;
  logic [31:0]      c;

  assign c = 32'(cnt_q);

  always_comb begin
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    pend_d   = pend_q;
    dly_d    = dly_q;
    qf_d     = 1'b0;
    hf_d     = 1'b0;
    irq_step = 1'b0;

    if (cpu_ce) begin
      // A strobe that coincides with a write does not count toward the delay.
      if (pend_q && !wr_en && dly_q == 3'd1) begin
        // Deferred counter reset; replaces any step event on this strobe.
        cnt_d  = '0;
        pend_d = 1'b0;
        dly_d  = '0;
        qf_d   = (mode_q == FS_MODE5);
        hf_d   = (mode_q == FS_MODE5);
      end else begin
        if (pend_q && !wr_en) begin
          dly_d = dly_q - 3'd1;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (c == FS_STEP1 || c == FS_STEP3) begin
          qf_d = 1'b1;
        end
        if (c == FS_STEP2) begin
          qf_d = 1'b1;
          hf_d = 1'b1;
        end
        if (mode_q == FS_MODE4) begin
          if (c == FS_IRQ_PRE) begin
            irq_step = 1'b1;
          end
          if (c == FS_STEP4) begin
            qf_d     = 1'b1;
            hf_d     = 1'b1;
            irq_step = 1'b1;
            cnt_d    = '0;
          end
        end else begin
          if (c == FS_STEP5) begin
            qf_d = 1'b1;
            hf_d = 1'b1;
          end
          if (c == FS_WRAP5) begin
            cnt_d = '0;
          end
        end
      end
    end

    // A write (re)arms the deferred reset; repeated writes restart the delay.
    if (wr_en) begin
      mode_d = fs_mode_e'(wr_data[7]);
      pend_d = 1'b1;
      dly_d  = 3'(RESET_DELAY);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      mode_q <= FS_MODE4;
      pend_q <= 1'b0;
      dly_q  <= '0;
      qf_q   <= 1'b0;
      hf_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      pend_q <= pend_d;
      dly_q  <= dly_d;
      qf_q   <= qf_d;
      hf_q   <= hf_d;
    end
  end

  assign quarter_frame = qf_q;
  assign half_frame    = hf_q;
  assign mode          = (mode_q == FS_MODE5);

`ifdef FRAME_IRQ_EN
  logic inhibit_q, inhibit_d;

  assign inhibit_d = wr_en ? wr_data[6] : inhibit_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inhibit_q <= 1'b0;
    end else begin
      inhibit_q <= inhibit_d;
    end
  end

  apu_frame_irq u_frame_irq (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_wr (wr_en & wr_data[6]),
    .set    (irq_step & ~inhibit_q),
    .clr_rd (status_rd),
    .irq    (frame_irq)
  );

  logic unused_wr;
  assign unused_wr = ^wr_data[5:0];
`else
  assign frame_irq = 1'b0;

  logic unused_wr;
  assign unused_wr = ^{irq_step, status_rd, wr_data[6:0]};
`endif

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Self-checking bench for apu_frame_sequencer: a behavioural model of the step
// schedule is compared against the DUT every clock, plus literal spot checks.
module tb_apu_frame_sequencer;

  localparam int unsigned RD = 3;
`ifdef FRAME_IRQ_EN
  localparam logic IRQ_EXP = 1'b1;
`else
  localparam logic IRQ_EXP = 1'b0;
`endif

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       cpu_ce    = 1'b0;
  logic       wr_en     = 1'b0;
  logic [7:0] wr_data   = 8'h00;
  logic       status_rd = 1'b0;
  logic       quarter_frame, half_frame, frame_irq, mode;

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  apu_frame_sequencer #(
    .RESET_DELAY (RD),
    .CNT_W       (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_ce        (cpu_ce),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .status_rd     (status_rd),
    .quarter_frame (quarter_frame),
    .half_frame    (half_frame),
    .frame_irq     (frame_irq),
    .mode          (mode)
  );

  // Behavioural model: position within the sequence and schedule rules.
  int m_pos  = 0;
  bit m_m5   = 1'b0;
  bit m_inh  = 1'b0;
  bit m_irq  = 1'b0;
  bit m_pend = 1'b0;
  int m_left = 0;
  bit e_q    = 1'b0;
  bit e_h    = 1'b0;

  task automatic model_step();
    bit q, h, set;
    int period, last;
    q = 1'b0;
    h = 1'b0;
    set = 1'b0;
    if (!rst_n) begin
      m_pos = 0; m_m5 = 0; m_inh = 0; m_irq = 0; m_pend = 0; m_left = 0;
    end else begin
      if (cpu_ce) begin
        if (m_pend && !wr_en && m_left == 1) begin
          m_pend = 0;
          m_pos  = 0;
          q = m_m5;
          h = m_m5;
        end else begin
          if (m_pend && !wr_en) m_left = m_left - 1;
          period = m_m5 ? 37282 : 29830;
          last   = m_m5 ? 37280 : 29829;
          q   = (m_pos == 7456 || m_pos == 14912 || m_pos == 22370 || m_pos == last);
          h   = (m_pos == 14912 || m_pos == last);
          set = !m_m5 && (m_pos == 29828 || m_pos == 29829);
          m_pos = (m_pos == period - 1) ? 0 : (m_pos + 1) % 65536;
        end
      end
`ifdef FRAME_IRQ_EN
      if (wr_en && wr_data[6]) m_irq = 0;
      else if (set && !m_inh) m_irq = 1;
      else if (status_rd) m_irq = 0;
`endif
      if (wr_en) begin
        m_m5   = wr_data[7];
        m_inh  = wr_data[6];
        m_pend = 1;
        m_left = RD;
      end
    end
    e_q = q;
    e_h = h;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("quarter_frame", quarter_frame, e_q);
      chk("half_frame", half_frame, e_h);
      chk("frame_irq", frame_irq, m_irq);
      chk("mode", mode, m_m5);
    end
  end

  task automatic drive(input bit ce, input bit sr, input bit we, input logic [7:0] wd);
    @(negedge clk);
    cpu_ce    = ce;
    status_rd = sr;
    wr_en     = we;
    wr_data   = wd;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit ce, input bit sr, input bit we, input logic [7:0] wd);
    drive(ce, sr, we, wd);
    settle();
  endtask

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while (m_pos != target && guard < 70000) begin
      step(1'b1, ($urandom_range(63) == 0), 1'b0, 8'h00);
      guard++;
    end
    if (m_pos != target) begin
      n_tests++;
      n_fail++;
      $display("FAIL run_to: position %0d, wanted %0d", m_pos, target);
    end
  endtask

  initial begin
    // Reset state
    drive(0, 0, 0, 8'h00);
    drive(0, 0, 0, 8'h00);
    started = 1'b1;
    settle();
    chk("rst_quarter", quarter_frame, 1'b0);
    chk("rst_half", half_frame, 1'b0);
    chk("rst_irq", frame_irq, 1'b0);
    chk("rst_mode", mode, 1'b0);
    drive(0, 0, 0, 8'h00);
    rst_n = 1'b1;

    // Mode 4 from reset: strobes every 2 clk, then random gaps, then dense.
    for (int i = 0; i < 200; i++) step(i[0], 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 300; i++) step($urandom_range(1), ($urandom_range(31) == 0), 1'b0, 8'h00);
    run_to(7456);
    step(1, 0, 0, 8'h00);
    chk("q_7456", quarter_frame, 1'b1);
    chk("h_7456", half_frame, 1'b0);
    run_to(14912);
    step(1, 0, 0, 8'h00);
    chk("q_14912", quarter_frame, 1'b1);
    chk("h_14912", half_frame, 1'b1);
    run_to(29828);
    step(1, 0, 0, 8'h00);
    chk("irq_set_29828", frame_irq, IRQ_EXP);
    chk("q_29828", quarter_frame, 1'b0);
    step(0, 1, 0, 8'h00);
    chk("irq_cleared_by_read", frame_irq, 1'b0);
    step(1, 1, 0, 8'h00);
    chk("q_29829", quarter_frame, 1'b1);
    chk("h_29829", half_frame, 1'b1);
    chk("irq_set_beats_read", frame_irq, IRQ_EXP);

    // Inhibit write clears the flag.
    step(0, 0, 1, 8'h40);
    chk("irq_cleared_by_inhibit", frame_irq, 1'b0);
    for (int i = 0; i < 40; i++) step(1, ($urandom_range(7) == 0), 0, 8'h00);
    chk("irq_stays_inhibited", frame_irq, 1'b0);

    // 5-step mode: immediate Q+H at the deferred reset.
    step(0, 0, 1, 8'h80);
    chk("mode_5", mode, 1'b1);
    step(1, 0, 0, 8'h00);
    chk("no_q_delay1", quarter_frame, 1'b0);
    step(1, 0, 0, 8'h00);
    chk("no_q_delay2", quarter_frame, 1'b0);
    step(1, 0, 0, 8'h00);
    chk("q_at_reset5", quarter_frame, 1'b1);
    chk("h_at_reset5", half_frame, 1'b1);
    run_to(7456);
    step(1, 0, 0, 8'h00);
    chk("q5_7456", quarter_frame, 1'b1);
    run_to(29829);
    step(1, 0, 0, 8'h00);
    chk("q5_none_29829", quarter_frame, 1'b0);
    chk("irq5_none", frame_irq, 1'b0);
    run_to(37280);
    step(1, 0, 0, 8'h00);
    chk("q5_37280", quarter_frame, 1'b1);
    chk("h5_37280", half_frame, 1'b1);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 8'h00);

    // Second write restarts the delay.
    step(0, 0, 1, 8'h80);
    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    step(0, 0, 1, 8'h80);
    step(1, 0, 0, 8'h00);
    chk("restart_no_stale", quarter_frame, 1'b0);
    step(1, 0, 0, 8'h00);
    chk("restart_wait", quarter_frame, 1'b0);
    step(1, 0, 0, 8'h00);
    chk("restart_q", quarter_frame, 1'b1);
    chk("restart_h", half_frame, 1'b1);

    // Reset while a write is pending.
    step(0, 0, 1, 8'h80);
    step(1, 0, 0, 8'h00);
    drive(1, 0, 0, 8'h00);
    rst_n = 1'b0;
    settle();
    chk("midrst_q", quarter_frame, 1'b0);
    chk("midrst_h", half_frame, 1'b0);
    chk("midrst_irq", frame_irq, 1'b0);
    chk("midrst_mode", mode, 1'b0);
    drive(0, 0, 0, 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 8'h00);
      chk("no_deferred_reset", quarter_frame, 1'b0);
    end

    // Random traffic: writes, reads, strobe gaps, occasional reset.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(3) != 0), ($urandom_range(31) == 0), ($urandom_range(149) == 0),
            8'($urandom_range(255)));
      rst_n = ($urandom_range(399) != 0);
    end
    drive(0, 0, 0, 8'h00);
    rst_n = 1'b1;
    settle();
    settle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apu_frame_sequencer.md
# apu_frame_sequencer

Frame sequencer for the PAPU: the controller that paces the length counters and envelope/linear-counter units of the square, triangle and noise channels. Counts CPU-cycle strobes and emits single-clock quarter-frame and half-frame ticks in 4-step or 5-step mode. Also owns the frame IRQ flag. Programmed by CPU writes to $4017; the flag is cleared by reads of $4015.

## Interface
Parameters:
- RESET_DELAY, 3, number of cpu_ce strobes between a $4017 write and the counter reset (legal 1..7)
- CNT_W, 16, width of the cycle counter

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- cpu_ce  in  1  one-clk strobe per CPU cycle
- wr_en  in  1  one-clk write strobe for $4017
- wr_data  in  8  write data; bit7 = mode (1 = 5-step), bit6 = IRQ inhibit
- status_rd  in  1  one-clk strobe: CPU read of $4015
- quarter_frame  out  1  one-clk pulse to envelopes and triangle linear counter
- half_frame  out  1  one-clk pulse to length counters and sweeps
- frame_irq  out  1  frame IRQ flag (level)
- mode  out  1  current sequencer mode

## Operation
- Registers: cnt[CNT_W-1:0], mode, inhibit, irq_flag, pend (reset pending), dly[2:0].
- Step decode uses C, the value of cnt on a cpu_ce clock. cnt increments on that clock.
- 4-step mode:
  - C=7456: Q.
  - C=14912: Q+H.
  - C=22370: Q.
  - C=29828: IRQ set.
  - C=29829: Q+H and IRQ set; cnt wraps to 0. Period is 29830.
- 5-step mode:
  - C=7456: Q.
  - C=14912: Q+H.
  - C=22370: Q.
  - C=37280: Q+H.
  - C=37281: cnt wraps to 0. Period is 37282. No IRQ is ever set.
- IRQ set only applies when inhibit=0.
- Write ($4017):
  - mode and inhibit load from wr_data on the wr_en clock.
  - inhibit=1 clears irq_flag on that clock.
  - pend=1 and dly=RESET_DELAY.
- Pending reset:
  - Each cpu_ce decrements dly. The old sequence keeps running, decoded under the new mode.
  - On the cpu_ce where dly reaches 0: cnt=0 and pend=0.
  - If mode=1, Q+H are emitted immediately at the reset.
  - That cpu_ce produces no other step event.
- Write while pend=1: restarts dly at RESET_DELAY.
- wr_en coincident with cpu_ce: that cpu_ce does not count toward the delay.
- IRQ priority, highest first:
  1. Write with inhibit=1 (clears).
  2. Step set.
  3. status_rd (clears).
- A set and a status_rd in the same clock leave the flag set.

## Timing
- Reset values: cnt=0, mode=0, inhibit=0, irq_flag=0, pend=0, quarter_frame=0, half_frame=0, frame_irq=0.
- Outputs are registered. A step event decoded on a cpu_ce clock appears on quarter_frame/half_frame on the next clock, for exactly one clk.
- frame_irq rises one clk after the setting cpu_ce and falls one clk after the clearing strobe.
- mode output follows the internal register; it updates one clk after wr_en.
- rst_n low mid-sequence or mid-pending: everything returns to reset values on that clock; the pending write is discarded.
- cpu_ce is absent for clocks with no strobe; no state changes except write and status handling.

## Configuration
- FRAME_IRQ_EN defined: IRQ flag, inhibit bit and status_rd logic as above.
- FRAME_IRQ_EN undefined:
  - irq_flag and inhibit are removed.
  - frame_irq is tied 0; wr_data[6] and status_rd are ignored.
  - Step timing is unchanged.

## Structure
- Shared package apu_pkg holds:
  - localparams FS_STEP1=7456, FS_STEP2=14912, FS_STEP3=22370, FS_STEP4=29829, FS_STEP5=37280, FS_WRAP5=37281, FS_IRQ_PRE=29828
  - typedef fs_mode_e {FS_MODE4, FS_MODE5}
- One sub-module: apu_frame_irq, the flag register with set/clear priority, compiled only under FRAME_IRQ_EN.
- Step decode and counter stay in apu_frame_sequencer.

## Test plan
- Run from reset, mode 4, cpu_ce every 2 clk:
  - Q pulses after C=7456, 14912, 22370 and 29829; H pulses after 14912 and 29829.
  - frame_irq rises after C=29828.
  - cnt returns to 0 after 29830 strobes.
- Write 0x80 (RESET_DELAY=3):
  - Q+H pulse one clk after the 3rd following cpu_ce; cnt=0.
  - Next Q at C=7456; Q+H at C=37280.
  - frame_irq never rises.
- With frame_irq=1, assert status_rd → frame_irq=0 next clk. Assert status_rd on the same clk as the C=29829 set → frame_irq stays 1.
- Write 0x40 while frame_irq=1 → frame_irq=0 next clk; it stays 0 across a full 29830-cycle period.
- Second write 2 cpu_ce after the first → reset occurs 3 cpu_ce after the second write. Then assert rst_n=0 mid-pending → all outputs 0, mode=0, and there is no deferred reset.
- Build without FRAME_IRQ_EN, mode 4 → frame_irq constant 0; Q/H timing identical to the first scenario.
